// File: rtl/axis_frame_loopback.sv
// Store-and-forward AXI-Stream loopback between the 10G MAC RX and TX ports.
// Frames are committed only on a clean tlast; bad and overflowing frames are rewound away whole.
module axis_frame_loopback #(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int DEPTH          = 512,
  parameter bit DROP_BAD_FRAME = 1'b1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk156,
  input  logic                  rst,
  output logic                  s_axis_rx_tready,
  input  logic                  s_axis_rx_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rx_tkeep,
  input  logic                  s_axis_rx_tlast,
  input  logic                  s_axis_rx_tuser,
  input  logic                  m_axis_tx_tready,
  output logic                  m_axis_tx_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
  output logic                  m_axis_tx_tlast,
  output logic                  m_axis_tx_tuser,
  output logic [CNT_WIDTH-1:0]  stat_good_frames,
  output logic [CNT_WIDTH-1:0]  stat_bad_frames,
  output logic [CNT_WIDTH-1:0]  stat_overflow_frames
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [PW-1:0]        FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0]        PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_t;

  logic [WW-1:0]        mem_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r, wr_commit_r, rd_ptr_r, fill_s;
  wr_state_t            wr_state_r;
  logic                 rx_ready_r, rx_acc_s, full_s, bad_s, mem_we_s;
  logic [CNT_WIDTH-1:0] good_cnt_r, bad_cnt_r, ovf_cnt_r;
  logic [WW-1:0]        ram_q_r, out0_r, out1_r, out0_nxt_s, out1_nxt_s;
  logic                 ram_vld_r, tx_vld_r, pop_s, rd_issue_s, have_data_s;
  logic [1:0]           cnt_r, cnt_nxt_s;
  logic [2:0]           occ_s;

  assign rx_acc_s    = s_axis_rx_tvalid & rx_ready_r;
  assign fill_s      = wr_ptr_r - rd_ptr_r;
  assign full_s      = (fill_s == FULL_LVL);
  assign bad_s       = s_axis_rx_tuser & DROP_BAD_FRAME;
  // A bad tlast beat is never written: the rewind discards the frame anyway.
  assign mem_we_s    = rx_acc_s & ~rst & (wr_state_r != ST_DROP) & ~full_s & ~(s_axis_rx_tlast & bad_s);

  assign have_data_s = (wr_commit_r != rd_ptr_r);
  assign pop_s       = tx_vld_r & m_axis_tx_tready;
  assign occ_s       = {1'b0, cnt_r} + {2'b00, ram_vld_r};
  // Prefetch only while skid slots plus the in-flight read leave room after this cycle's pop.
  assign rd_issue_s  = have_data_s & (occ_s < (3'd2 + {2'b00, pop_s}));

  // Write FSM: speculative write, commit on a clean tlast, rewind on bad frame or overflow.
  always_ff @(posedge clk156) begin
    if (rst) begin
      wr_ptr_r    <= {PW{1'b0}};
      wr_commit_r <= {PW{1'b0}};
      wr_state_r  <= ST_IDLE;
      rx_ready_r  <= 1'b0;
      good_cnt_r  <= {CNT_WIDTH{1'b0}};
      bad_cnt_r   <= {CNT_WIDTH{1'b0}};
      ovf_cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      rx_ready_r <= 1'b1;
      if (rx_acc_s) begin
        case (wr_state_r)
          ST_IDLE, ST_RECV: begin
            if (full_s) begin
              wr_ptr_r   <= wr_commit_r;
              ovf_cnt_r  <= ovf_cnt_r + CNT_ONE;
              wr_state_r <= s_axis_rx_tlast ? ST_IDLE : ST_DROP;
            end else if (s_axis_rx_tlast && bad_s) begin
              wr_ptr_r   <= wr_commit_r;
              bad_cnt_r  <= bad_cnt_r + CNT_ONE;
              wr_state_r <= ST_IDLE;
            end else if (s_axis_rx_tlast) begin
              wr_ptr_r    <= wr_ptr_r + PTR_ONE;
              wr_commit_r <= wr_ptr_r + PTR_ONE;
              good_cnt_r  <= good_cnt_r + CNT_ONE;
              wr_state_r  <= ST_IDLE;
            end else begin
              wr_ptr_r   <= wr_ptr_r + PTR_ONE;
              wr_state_r <= ST_RECV;
            end
          end
          ST_DROP: begin
            if (s_axis_rx_tlast) begin
              wr_state_r <= ST_IDLE;
            end
          end
          default: wr_state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // Frame buffer: one write port from RX, one registered read port feeding the skid.
  always_ff @(posedge clk156) begin
    if (mem_we_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata};
    end
    if (rd_issue_s) begin
      ram_q_r <= mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Output skid: out0 drives TX, out1 absorbs the in-flight RAM read while TX stalls.
  always_comb begin
    out0_nxt_s = out0_r;
    out1_nxt_s = out1_r;
    cnt_nxt_s  = cnt_r;
    case (cnt_r)
      2'd0: begin
        if (ram_vld_r) begin
          out0_nxt_s = ram_q_r;
          cnt_nxt_s  = 2'd1;
        end else begin
          cnt_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (pop_s && ram_vld_r) begin
          out0_nxt_s = ram_q_r;
        end else if (pop_s) begin
          cnt_nxt_s = 2'd0;
        end else if (ram_vld_r) begin
          out1_nxt_s = ram_q_r;
          cnt_nxt_s  = 2'd2;
        end else begin
          cnt_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          out0_nxt_s = out1_r;
          if (ram_vld_r) begin
            out1_nxt_s = ram_q_r;
          end else begin
            cnt_nxt_s = 2'd1;
          end
        end else begin
          cnt_nxt_s = 2'd2;
        end
      end
      default: cnt_nxt_s = 2'd0;
    endcase
  end

  // Read side registers: read pointer, RAM read valid, skid contents and TX valid.
  always_ff @(posedge clk156) begin
    if (rst) begin
      rd_ptr_r  <= {PW{1'b0}};
      ram_vld_r <= 1'b0;
      cnt_r     <= 2'd0;
      tx_vld_r  <= 1'b0;
      out0_r    <= {WW{1'b0}};
      out1_r    <= {WW{1'b0}};
    end else begin
      if (rd_issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      ram_vld_r <= rd_issue_s;
      cnt_r     <= cnt_nxt_s;
      tx_vld_r  <= (cnt_nxt_s != 2'd0);
      out0_r    <= out0_nxt_s;
      out1_r    <= out1_nxt_s;
    end
  end

  assign s_axis_rx_tready     = rx_ready_r;
  assign m_axis_tx_tvalid     = tx_vld_r;
  assign m_axis_tx_tdata      = out0_r[DATA_WIDTH-1:0];
  assign m_axis_tx_tkeep      = out0_r[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tx_tlast      = out0_r[WW-1];
  assign m_axis_tx_tuser      = 1'b0;
  assign stat_good_frames     = good_cnt_r;
  assign stat_bad_frames      = bad_cnt_r;
  assign stat_overflow_frames = ovf_cnt_r;

endmodule
